// File: rtl/tape_pkg.sv
// Shared types for the tape-save capture path: FSM states, interval classes and sync patterns.
package tape_pkg;

    typedef enum logic [2:0] {IDLE, HUNT, DATA, DONE, ERR} tape_state_e;

    typedef enum logic [1:0] {SHORT, LONG, BAD} ivl_class_e;

    // Sync byte as seen on a normal line, and as seen when the line polarity is flipped.
    localparam logic [7:0] SYNC_BYTE = 8'hE6;
    localparam logic [7:0] SYNC_INV  = 8'h19;

endpackage

// File: rtl/tape_buf_ram.sv
// Capture buffer: one write port, one registered read port, sized to map onto block RAM.
module tape_buf_ram #(
    parameter int AW = 14
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk_sys) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Output register clears on reset so the host port reads zero while held in reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rd_data <= 8'h00;
        else          rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tape_rks_capture.sv
// Decodes the bi-phase tape-out line into bytes and buffers them for upload as an .RKS image.
module tape_rks_capture
    import tape_pkg::*;
#(
    parameter int BUF_AW   = 14,
    parameter int HALF_MIN = 120,
    parameter int HALF_MAX = 240,
    parameter int FULL_MAX = 480,
    parameter int TIMEOUT  = 8000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              tape_in,
    input  logic              arm,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [BUF_AW:0]   byte_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              overflow
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam int              BW       = BUF_AW + 1;
    localparam logic [CW-1:0]   TO_CNT   = CW'(TIMEOUT);
    localparam logic [BW-1:0]   LAST_IDX = BW'((2**BUF_AW) - 1);

    tape_state_e   state, state_nxt;
    logic          tape_s1, tape_s2, tape_prev, tape_edge;
    logic [CW-1:0] ivl_cnt;
    ivl_class_e    ivl_cls;
    logic          mid, bit_vld, bit_val, inv;
    logic [7:0]    sr, sr_nxt, data_byte;
    logic [2:0]    bit_cnt;
    logic          clr, hunt_rst, enter_data, data_bit, we, set_done, set_err, set_ovf;

    function automatic ivl_class_e classify(input logic [CW-1:0] n);
        if (n >= CW'(HALF_MIN) && n < CW'(HALF_MAX))  return SHORT;
        if (n >= CW'(HALF_MAX) && n <= CW'(FULL_MAX)) return LONG;
        return BAD;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tape_s1   <= 1'b0;
            tape_s2   <= 1'b0;
            tape_prev <= 1'b0;
            ivl_cnt   <= '0;
        end else begin
            tape_s1   <= tape_in;
            tape_s2   <= tape_s1;
            tape_prev <= tape_s2;
            if (tape_edge)                    ivl_cnt <= '0;
            else if (ce && ivl_cnt != TO_CNT) ivl_cnt <= ivl_cnt + 1'b1;
        end
    end

    // A bit is carried by every mid-bit edge; short edges alternate boundary/mid.
    assign tape_edge = tape_s2 ^ tape_prev;
    assign ivl_cls   = classify(ivl_cnt);
    assign bit_val   = tape_s2;
    assign bit_vld   = tape_edge && (ivl_cls == LONG || (ivl_cls == SHORT && !mid));
    assign data_byte = {sr[6:0], bit_val ^ inv};
    assign busy      = (state == HUNT) || (state == DATA);

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        clr        = 1'b0;
        hunt_rst   = 1'b0;
        enter_data = 1'b0;
        data_bit   = 1'b0;
        we         = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        set_ovf    = 1'b0;
        if (arm) begin
            state_nxt = HUNT;
            clr       = 1'b1;
            sr_nxt    = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (tape_edge && ivl_cls == BAD) begin
                        hunt_rst = 1'b1;
                        sr_nxt   = '0;
                    end else if (bit_vld) begin
                        sr_nxt = {sr[6:0], bit_val};
                        if (sr_nxt == SYNC_BYTE || sr_nxt == SYNC_INV) begin
                            state_nxt  = DATA;
                            enter_data = 1'b1;
                        end
                    end
                end
                DATA: begin
                    // An edge always takes priority over a coincident timeout.
                    if (tape_edge) begin
                        if (ivl_cls == BAD) begin
                            state_nxt = ERR;
                            set_err   = 1'b1;
                        end else if (bit_vld) begin
                            data_bit = 1'b1;
                            sr_nxt   = data_byte;
                            if (bit_cnt == 3'd7) begin
                                we = 1'b1;
                                if (byte_cnt == LAST_IDX) begin
                                    state_nxt = DONE;
                                    set_done  = 1'b1;
                                    set_ovf   = 1'b1;
                                end
                            end
                        end
                    end else if (ivl_cnt == TO_CNT) begin
                        state_nxt = DONE;
                        set_done  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            overflow <= 1'b0;
            mid      <= 1'b1;
            inv      <= 1'b0;
            bit_cnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (clr)     byte_cnt <= '0;
            else if (we) byte_cnt <= byte_cnt + 1'b1;
            if (clr)           done <= 1'b0;
            else if (set_done) done <= 1'b1;
            if (clr)          err <= 1'b0;
            else if (set_err) err <= 1'b1;
            if (clr)          overflow <= 1'b0;
            else if (set_ovf) overflow <= 1'b1;
            if (clr || hunt_rst) mid <= 1'b1;
            else if (tape_edge)  mid <= (ivl_cls != SHORT) || !mid;
            if (enter_data) inv <= (sr_nxt == SYNC_INV);
            if (clr || enter_data) bit_cnt <= 3'd0;
            else if (data_bit)     bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        sr <= sr_nxt;
    end

    tape_buf_ram #(.AW(BUF_AW)) u_buf (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .we      (we),
        .wr_addr (byte_cnt[BUF_AW-1:0]),
        .wr_data (data_byte),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
